// File: rtl/rf_access_arbiter.sv
// Round-robin, burst-limited arbiter sharing the register-file access path between the core (req 0) and the host loader (req 1).
// Optional macro RF_WRITE_PROTECT_EN blocks host writes to the low protected registers and flags them on prot_err_o.
module rf_access_arbiter #(
    parameter int DW         = 26,
    parameter int AW         = 5,
    parameter int MAX_BURST  = 4,
    parameter int PROT_LIMIT = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req_i,
    input  logic [1:0]      wr_i,
    input  logic [2*AW-1:0] src0_i,
    input  logic [2*AW-1:0] src1_i,
    input  logic [2*AW-1:0] dst_i,
    input  logic [2*DW-1:0] wdata_i,
    output logic [1:0]      gnt_o,
    output logic [1:0]      rvalid_o,
    output logic [DW-1:0]   rdata0_o,
    output logic [DW-1:0]   rdata1_o,
    output logic            prot_err_o,
    output logic [AW-1:0]   rf_src0,
    output logic [AW-1:0]   rf_src1,
    output logic [AW-1:0]   rf_dst,
    output logic            rf_we,
    output logic [DW-1:0]   rf_data,
    input  logic [DW-1:0]   rf_data0,
    input  logic [DW-1:0]   rf_data1
);

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);
`ifdef RF_WRITE_PROTECT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN0 = 2'd1,
        S_OWN1 = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      rvalid_q, rvalid_d;
    logic [DW-1:0]   rdata0_q, rdata1_q;
    logic            prot_err_q;

    logic            owner_s;
    logic            other_s;
    logic [1:0]      gnt_s;
    logic [AW-1:0]   dst_s;
    logic            blocked_s;

    // Next-state, burst counting and round-robin pointer update
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        gnt_s    = 2'b00;
        owner_s  = 1'b0;
        other_s  = 1'b1;
        case (state_q)
            S_IDLE: begin
                cnt_d = {CW{1'b0}};
                if (req_i[0] && req_i[1]) begin
                    state_d = rr_ptr_q ? S_OWN1 : S_OWN0;
                end else if (req_i[0]) begin
                    state_d = S_OWN0;
                end else if (req_i[1]) begin
                    state_d = S_OWN1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_OWN0, S_OWN1: begin
                owner_s        = (state_q == S_OWN1);
                other_s        = ~owner_s;
                gnt_s[owner_s] = req_i[owner_s];
                if (!req_i[owner_s]) begin
                    cnt_d    = {CW{1'b0}};
                    rr_ptr_d = other_s;
                    state_d  = req_i[other_s] ? (other_s ? S_OWN1 : S_OWN0) : S_IDLE;
                end else if (req_i[other_s] && (cnt_q == BURST_LAST)) begin
                    cnt_d    = {CW{1'b0}};
                    rr_ptr_d = other_s;
                    state_d  = other_s ? S_OWN1 : S_OWN0;
                end else if (cnt_q != BURST_LAST) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // Owner-selected regfile access path; IDLE presents requester 0's fields
    always_comb begin
        dst_s     = owner_s ? dst_i[2*AW-1:AW] : dst_i[AW-1:0];
        rf_src0   = owner_s ? src0_i[2*AW-1:AW] : src0_i[AW-1:0];
        rf_src1   = owner_s ? src1_i[2*AW-1:AW] : src1_i[AW-1:0];
        rf_data   = owner_s ? wdata_i[2*DW-1:DW] : wdata_i[DW-1:0];
        rf_dst    = dst_s;
        // Host writes into the constant area are consumed but never reach the regfile
        blocked_s = PROT_EN & owner_s & wr_i[1] & (int'(dst_s) < PROT_LIMIT);
        rf_we     = (|gnt_s) & wr_i[owner_s] & ~blocked_s;
        rvalid_d  = gnt_s & ~wr_i;
    end

    // State, read-return and sticky error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= 1'b0;
            cnt_q      <= {CW{1'b0}};
            rvalid_q   <= 2'b00;
            rdata0_q   <= {DW{1'b0}};
            rdata1_q   <= {DW{1'b0}};
            prot_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            if (|rvalid_d) begin
                rdata0_q <= rf_data0;
                rdata1_q <= rf_data1;
            end
            if ((|gnt_s) && blocked_s) begin
                prot_err_q <= 1'b1;
            end
        end
    end

    assign gnt_o      = gnt_s;
    assign rvalid_o   = rvalid_q;
    assign rdata0_o   = rdata0_q;
    assign rdata1_o   = rdata1_q;
    assign prot_err_o = prot_err_q;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed bench for rf_access_arbiter with a behavioural 32x26 register file behind it.
// Expectations for host writes to protected registers follow RF_WRITE_PROTECT_EN.
module tb_rf_access_arbiter;

    localparam int DW = 26;
    localparam int AW = 5;
`ifdef RF_WRITE_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      req_i;
    logic [1:0]      wr_i;
    logic [2*AW-1:0] src0_i, src1_i, dst_i;
    logic [2*DW-1:0] wdata_i;
    logic [1:0]      gnt_o, rvalid_o;
    logic [DW-1:0]   rdata0_o, rdata1_o;
    logic            prot_err_o;
    logic [AW-1:0]   rf_src0, rf_src1, rf_dst;
    logic            rf_we;
    logic [DW-1:0]   rf_data, rf_data0, rf_data1;

    logic [DW-1:0]   regis [32];
    logic            init_done = 1'b0;
    int              n_cmp = 0;
    int              n_err = 0;
    logic [1:0]      burst_exp [10];

    rf_access_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .wr_i(wr_i),
        .src0_i(src0_i), .src1_i(src1_i), .dst_i(dst_i), .wdata_i(wdata_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata0_o(rdata0_o), .rdata1_o(rdata1_o),
        .prot_err_o(prot_err_o), .rf_src0(rf_src0), .rf_src1(rf_src1), .rf_dst(rf_dst),
        .rf_we(rf_we), .rf_data(rf_data), .rf_data0(rf_data0), .rf_data1(rf_data1)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int idx);
        if (idx == 0)      return 26'h000AC41;
        else if (idx == 1) return 26'h0000053;
        else               return DW'(idx * 32'h0010101);
    endfunction

    // Behavioural register file: preload, then synchronous write / combinational read
    always_ff @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 32; i++) regis[i] <= init_val(i);
        end else if (rf_we) begin
            regis[rf_dst] <= rf_data;
        end
    end
    assign rf_data0 = regis[rf_src0];
    assign rf_data1 = regis[rf_src1];

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        burst_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
        rst_n   = 1'b0;
        req_i   = 2'b00;
        wr_i    = 2'b00;
        src0_i  = '0;
        src1_i  = '0;
        dst_i   = '0;
        wdata_i = '0;
        step();
        step();
        smp();
        init_done = 1'b1;
        chk_eq("rst_gnt", 32'(gnt_o), 32'h0);
        chk_eq("rst_rvalid", 32'(rvalid_o), 32'h0);
        chk_eq("rst_rdata0", 32'(rdata0_o), 32'h0);
        chk_eq("rst_rdata1", 32'(rdata1_o), 32'h0);
        chk_eq("rst_we", 32'(rf_we), 32'h0);
        chk_eq("rst_prot", 32'(prot_err_o), 32'h0);
        rst_n = 1'b1;

        // Single read by the core
        step();
        req_i  = 2'b01;
        src0_i = {5'd0, 5'd1};
        src1_i = {5'd0, 5'd0};
        smp();
        chk_eq("rd_idle_gnt", 32'(gnt_o), 32'h0);
        step();
        smp();
        chk_eq("rd_gnt", 32'(gnt_o), 32'h1);
        chk_eq("rd_src0", 32'(rf_src0), 32'd1);
        chk_eq("rd_we", 32'(rf_we), 32'h0);
        step();
        req_i = 2'b00;
        smp();
        chk_eq("rd_rvalid", 32'(rvalid_o), 32'h1);
        chk_eq("rd_rdata0", 32'(rdata0_o), 32'h000053);
        chk_eq("rd_rdata1", 32'(rdata1_o), 32'h00AC41);
        step();
        smp();
        chk_eq("rd_rvalid_drop", 32'(rvalid_o), 32'h0);
        chk_eq("rd_rdata0_hold", 32'(rdata0_o), 32'h000053);

        // Async reset asserted mid-cycle while requester 1 owns the path
        step();
        req_i = 2'b11;
        smp();
        chk_eq("pre_gnt_idle", 32'(gnt_o), 32'h0);
        step();
        smp();
        chk_eq("pre_gnt_own1", 32'(gnt_o), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("arst_gnt", 32'(gnt_o), 32'h0);
        chk_eq("arst_rvalid", 32'(rvalid_o), 32'h0);
        chk_eq("arst_rdata0", 32'(rdata0_o), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk_eq("arst_rel_gnt", 32'(gnt_o), 32'h0);

        // Both requesters held: bursts of four from rr_ptr = 0
        for (int i = 0; i < 10; i++) begin
            smp();
            chk_eq($sformatf("burst_gnt%0d", i), 32'(gnt_o), 32'(burst_exp[i]));
            if (i == 4) chk_eq("burst_rvalid4", 32'(rvalid_o), 32'h1);
            if (i == 8) chk_eq("burst_rvalid8", 32'(rvalid_o), 32'h2);
        end
        step();
        req_i = 2'b00;
        smp();
        chk_eq("burst_end_gnt", 32'(gnt_o), 32'h0);

        // Host write of reg 29 followed by core read of it
        step();
        req_i   = 2'b11;
        wr_i    = 2'b10;
        src0_i  = {5'd0, 5'd29};
        dst_i   = {5'd29, 5'd0};
        wdata_i = {26'h3FFFFFF, 26'h0};
        smp();
        chk_eq("wr_idle_gnt", 32'(gnt_o), 32'h0);
        step();
        smp();
        chk_eq("wr_gnt", 32'(gnt_o), 32'h2);
        chk_eq("wr_we", 32'(rf_we), 32'h1);
        chk_eq("wr_dst", 32'(rf_dst), 32'd29);
        chk_eq("wr_data", 32'(rf_data), 32'h3FFFFFF);
        step();
        req_i = 2'b01;
        smp();
        chk_eq("wr_handover_gnt", 32'(gnt_o), 32'h0);
        chk_eq("wr_regfile29", 32'(regis[29]), 32'h3FFFFFF);
        step();
        smp();
        chk_eq("rb_gnt", 32'(gnt_o), 32'h1);
        chk_eq("rb_src0", 32'(rf_src0), 32'd29);
        chk_eq("rb_we", 32'(rf_we), 32'h0);
        step();
        req_i = 2'b00;
        smp();
        chk_eq("rb_rvalid", 32'(rvalid_o), 32'h1);
        chk_eq("rb_rdata0", 32'(rdata0_o), 32'h3FFFFFF);

        // Sole requester 1 held: continuous grants, no IDLE gap
        step();
        req_i  = 2'b10;
        wr_i   = 2'b00;
        src0_i = {5'd1, 5'd0};
        src1_i = {5'd29, 5'd0};
        smp();
        chk_eq("solo_idle_gnt", 32'(gnt_o), 32'h0);
        for (int i = 0; i < 10; i++) begin
            step();
            smp();
            chk_eq($sformatf("solo_gnt%0d", i), 32'(gnt_o), 32'h2);
            if (i > 0) begin
                chk_eq($sformatf("solo_rvalid%0d", i), 32'(rvalid_o), 32'h2);
                chk_eq($sformatf("solo_rdata0_%0d", i), 32'(rdata0_o), 32'h000053);
                chk_eq($sformatf("solo_rdata1_%0d", i), 32'(rdata1_o), 32'h3FFFFFF);
            end
        end

        // Saturated owner yields after one more grant; both write reg 0
        step();
        req_i   = 2'b11;
        wr_i    = 2'b11;
        dst_i   = {5'd0, 5'd0};
        wdata_i = {26'h1234567, 26'h0ABCDEF};
        smp();
        chk_eq("p1_gnt", 32'(gnt_o), 32'h2);
        chk_eq("p1_we", 32'(rf_we), PROT ? 32'h0 : 32'h1);
        chk_eq("p1_dst", 32'(rf_dst), 32'd0);
        step();
        req_i = 2'b01;
        smp();
        chk_eq("p0_gnt", 32'(gnt_o), 32'h1);
        chk_eq("p0_we", 32'(rf_we), 32'h1);
        chk_eq("p0_data", 32'(rf_data), 32'h0ABCDEF);
        chk_eq("p0_rvalid", 32'(rvalid_o), 32'h0);
        chk_eq("p1_prot_err", 32'(prot_err_o), PROT ? 32'h1 : 32'h0);
        chk_eq("p1_regfile0", 32'(regis[0]), PROT ? 32'h00AC41 : 32'h1234567);
        step();
        req_i = 2'b00;
        smp();
        chk_eq("p0_regfile0", 32'(regis[0]), 32'h0ABCDEF);
        chk_eq("p0_prot_sticky", 32'(prot_err_o), PROT ? 32'h1 : 32'h0);
        chk_eq("p0_end_gnt", 32'(gnt_o), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
